// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side adapter between a synchronous FIFO and a
// valid/ready stream. A 3-entry prefetch buffer hides the FIFO's one-cycle
// read latency so one word per cycle is sustained. fifo_ren depends only on
// local registers and fifo_empty, never on m_ready.
//
// Optional feature: define FIFO_RD_STREAM_LAST_EN to build the beat counter
// that drives m_last every PKT_LEN beats. Without it m_last is tied low and
// the data path is unchanged.
module fifo_rd_stream #(
    parameter int WIDTH_FIFO = 8,
    parameter int PKT_LEN    = 16,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_ren,
    input  logic [WIDTH_FIFO-1:0] fifo_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WIDTH_FIFO-1:0] m_data,
    output logic                  m_last
);

    // PKT_LEN must fit in the beat counter and stay within 1..65535.
    localparam bit CFG_OK = (PKT_LEN >= 1) && (PKT_LEN <= 65535) &&
                            ((CNT_W >= 32) || ((64'd1 << CNT_W) >= 64'(PKT_LEN)));

    generate
        if (!CFG_OK) begin : g_bad_cfg
            $error("fifo_rd_stream: PKT_LEN out of range or CNT_W too narrow");
        end
    endgenerate

    logic [WIDTH_FIFO-1:0] buf_mem [3];
    logic [1:0]            head;
    logic [1:0]            tail;
    logic [1:0]            occ;
    logic                  inflight;
    logic [2:0]            level;
    logic                  rd_accept;
    logic                  push;
    logic                  pop;

    // Circular pointer increment over the three buffer slots.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Words already held plus the word on its way back from the FIFO.
    always_comb begin
        level = {1'b0, occ} + {2'b0, inflight};
    end

    // Only request when the returning word is guaranteed a free slot.
    assign fifo_ren  = !rst && !fifo_empty && (level < 3'd3);
    assign rd_accept = fifo_ren && !fifo_empty;
    assign push      = inflight;
    assign pop       = m_valid && m_ready;

    assign m_valid = (occ != 2'd0);
    assign m_data  = buf_mem[head];

    // Pointer, occupancy and in-flight tracking; an in-flight word is dropped on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            head     <= 2'd0;
            tail     <= 2'd0;
            occ      <= 2'd0;
        end else begin
            inflight <= rd_accept;
            if (push) begin
                tail <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Capture returning FIFO data at the tail; cleared so m_data reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                buf_mem[i] <= '0;
            end
        end else if (push) begin
            buf_mem[tail] <= fifo_rdata;
        end
    end

`ifdef FIFO_RD_STREAM_LAST_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PKT_LEN - 1);

    logic [CNT_W-1:0] cnt;

    // Beat position within the packet, advanced on every handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (pop) begin
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign m_last = m_valid && (cnt == CNT_MAX);
`else
    assign m_last = 1'b0;
`endif

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side adapter that sits directly downstream of the synchronous FIFO. It drains the FIFO through its `ren`/`empty`/`rdata` read port and presents the words as a valid/ready stream to the next stage. It absorbs the FIFO's one-cycle registered read latency with a 3-entry prefetch buffer, so it sustains one word per cycle with no combinational path from `m_ready` to `fifo_ren`.

## Interface
- `WIDTH_FIFO`, 8, data width; must match the FIFO's data width.
- `PKT_LEN`, 16, beats per packet for `m_last` generation; legal range 1..65535.
- `CNT_W`, 16, width of the beat counter; must satisfy 2^CNT_W ≥ PKT_LEN.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `fifo_empty`  in  1  FIFO `empty`.
- `fifo_ren`  out  1  FIFO `ren`.
- `fifo_rdata`  in  WIDTH_FIFO  FIFO `rdata`; valid the cycle after an accepted read.
- `m_valid`  out  1  stream word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  WIDTH_FIFO  stream word.
- `m_last`  out  1  last beat of packet; port always present.

## Operation
- **Read counting.** A FIFO read is *accepted* when `fifo_ren && !fifo_empty`.
- **In-flight flag.** `inflight` is a register set to the accepted-read condition each cycle. When `inflight` = 1, `fifo_rdata` is captured into the buffer tail that cycle.
- **Buffer.** 3-entry circular buffer with head/tail pointers (mod 3) and occupancy `occ` (0..3).
  - Push on `inflight`.
  - Pop on `m_valid && m_ready`.
  - Simultaneous push and pop leaves `occ` unchanged.
- **Read request.** `fifo_ren = !rst && !fifo_empty && (occ + inflight < 3)`.
  - Depends on registers and `fifo_empty` only, never on `m_ready`.
  - Guarantees no push ever finds the buffer full; overflow is impossible by construction.
- **Stream outputs.**
  - `m_valid = (occ != 0)`.
  - `m_data` = buffer head entry.
  - Once `m_valid` is high, `m_valid` and `m_data` hold stable until the handshake.
- **Ordering.** Words leave in exact FIFO order. No drop, no duplication.
- **Beat counter.** Counts 0..PKT_LEN-1, increments on each handshake, and wraps to 0 after PKT_LEN-1.
- **Reset.** Clears `occ`, `inflight`, pointers, buffer contents, and the beat counter.
  - A word in flight at reset is discarded.
  - Reset is normally applied together with the FIFO's own reset.

## Timing
- **Reset values.**
  - `fifo_ren` = 0 while `rst` is high (combinational gate).
  - `m_valid` = 0, `m_data` = 0, `m_last` = 0.
- **First-word latency.** `fifo_empty` falls in cycle N:
  - `fifo_ren` = 1 in N.
  - `fifo_rdata` is valid in N+1 and captured at the end of N+1.
  - `m_valid` = 1 in N+2.
- **Throughput.** Steady state with `m_ready` held high is `occ` = 1, `inflight` = 1, `fifo_ren` = 1, giving 1 word/cycle.
- **Backpressure.** With `m_ready` low:
  - At most 3 words are read, after which `fifo_ren` = 0 until a pop.
  - The cycle after the first pop, `fifo_ren` may reassert.
- **FIFO empty.** `fifo_ren` = 0 whenever `fifo_empty` = 1. In-flight data still lands. `m_valid` drops only when `occ` reaches 0.
- **Reset mid-transfer.** The cycle after `rst` is sampled high, all state is at reset values regardless of `occ`, `inflight`, or the handshake.

## Configuration
- Macro `FIFO_RD_STREAM_LAST_EN`.
- **Defined:** the beat counter is instantiated and `m_last = m_valid && (cnt == PKT_LEN-1)`. With `PKT_LEN` = 1, `m_last` = `m_valid` on every beat.
- **Undefined:** no counter logic; `m_last` is tied to 0. The data path is identical.

## Test plan
- **Single word.** Write 0xA5 to an empty FIFO, `m_ready` = 1. Required: `m_valid` high exactly 2 cycles after `empty` falls, `m_data` = 0xA5, then `m_valid` = 0, `occ` = 0.
- **Full-rate burst.** Preload 16 words 0x00..0x0F, `m_ready` = 1. Required: after the 2-cycle start-up, 16 consecutive handshakes in order 0x00..0x0F with no gaps, and `fifo_ren` never high when `occ + inflight` = 3.
- **Backpressure.** Preload 8 words, `m_ready` = 0 for 10 cycles, then 1. Required: exactly 3 FIFO reads during the stall, `m_data` held at 0x00 throughout, and all 8 words delivered afterwards in order.
- **Intermittent source.** FIFO writes on alternate cycles with random `m_ready`. Required: the output sequence equals the input sequence, with no read issued while `fifo_empty` = 1.
- **Reset mid-operation.** With `occ` = 2 and `inflight` = 1, pulse `rst` for 1 cycle. Required: next cycle `m_valid` = 0, `m_data` = 0, `fifo_ren` = 0 during `rst`, `m_last` = 0.
- **Packet framing.** Macro defined, `PKT_LEN` = 4, 12 words streamed. Required: `m_last` = 1 on beats 4, 8 and 12 only. With the macro undefined, `m_last` is constantly 0.
